// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: states, datapath selects and decoded-opcode fields.
// Purely declarative; no logic and no flow control live here.
// Included by every sequencer file through a package import.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_IM0     = 4'd1,
        S_ZP0     = 4'd2,
        S_ZP1     = 4'd3,
        S_ABS0    = 4'd4,
        S_ABS1    = 4'd5,
        S_ABSFIX  = 4'd6,
        S_ABS2    = 4'd7,
        S_IND_ZP0 = 4'd8,
        S_IND_ZP1 = 4'd9,
        S_IND_ZP2 = 4'd10,
        S_INDFIX  = 4'd11,
        S_IND_ZP3 = 4'd12
    } state_t;

    localparam logic [2:0] AS_PC   = 3'd0;
    localparam logic [2:0] AS_ZERO = 3'd1;
    localparam logic [2:0] AS_ABS  = 3'd2;
    localparam logic [2:0] AS_IND0 = 3'd3;
    localparam logic [2:0] AS_IND1 = 3'd4;

    localparam logic [1:0] AOP_ADR0 = 2'd0;
    localparam logic [1:0] AOP_ADR1 = 2'd1;
    localparam logic [1:0] AOP_ADC  = 2'd2;
    localparam logic [1:0] AOP_LD   = 2'd3;

    typedef enum logic [2:0] {M_IMM, M_ZP, M_ABS, M_INDX, M_INDY} mode_t;
    typedef enum logic [1:0] {C_LD, C_ADC, C_ST, C_OTH} op_class_t;
    // Register codes line up with both alu_select and store_select encodings.
    typedef enum logic [1:0] {R_A = 2'd0, R_X = 2'd1, R_Y = 2'd2, R_Z = 2'd3} reg_t;

    typedef struct packed {
        mode_t     mode;
        op_class_t op_class;
        reg_t      index_reg;
        reg_t      target;
        logic      is_store;
        logic      legal;
    } dec_t;

    function automatic logic [1:0] reg_sel(input reg_t r);
        return 2'(r);
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Opcode classifier: addressing mode, operation class, index and target register, legality.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [7:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '{mode: M_IMM, op_class: C_OTH, index_reg: R_Z, target: R_A,
                is_store: 1'b0, legal: 1'b0};
        if (opcode[1:0] == 2'b01) begin
            dec.legal = (opcode != 8'h89);
            case (opcode[4:2])
                3'd0: begin dec.mode = M_INDX; dec.index_reg = R_X; end
                3'd1: dec.mode = M_ZP;
                3'd2: dec.mode = M_IMM;
                3'd3: dec.mode = M_ABS;
                3'd4: begin dec.mode = M_INDY; dec.index_reg = R_Y; end
                3'd5: begin dec.mode = M_ZP;   dec.index_reg = R_X; end
                3'd6: begin dec.mode = M_ABS;  dec.index_reg = R_Y; end
                default: begin dec.mode = M_ABS; dec.index_reg = R_X; end
            endcase
            case (opcode[7:5])
                3'd3:    dec.op_class = C_ADC;
                3'd4:    dec.op_class = C_ST;
                3'd5:    dec.op_class = C_LD;
                default: dec.op_class = C_OTH;
            endcase
        end else begin
            // LDX/LDY/STX/STY: bit1 picks X over Y, bit5 picks load over store.
            dec.target   = opcode[1] ? R_X : R_Y;
            dec.op_class = opcode[5] ? C_LD : C_ST;
            case (opcode)
                8'hA0, 8'hA2:                 begin dec.legal = 1'b1; dec.mode = M_IMM; end
                8'hA4, 8'hA6, 8'h84, 8'h86:   begin dec.legal = 1'b1; dec.mode = M_ZP;  end
                8'hAC, 8'hAE, 8'h8C, 8'h8E:   begin dec.legal = 1'b1; dec.mode = M_ABS; end
                default:                      dec.legal = 1'b0;
            endcase
        end
        dec.is_store = (dec.op_class == C_ST);
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// CPU control sequencer: steps fetch/operand/address/execute cycles and emits datapath strobes.
// Latency: strobes are combinational from state, opcode_q and ready; state moves once per ready cycle.
// Backpressure: ready=0 freezes state and masks every strobe while selects and read_write hold.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int STATE_W      = 6,
    parameter int PAGE_PENALTY = 1,
    parameter int RDY_EN       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         opcode,
    input  logic               ready,
    input  logic               page_cross,
    output logic               instruction_load,
    output logic               increment_pc,
    output logic               indirl_load,
    output logic               dirl_load,
    output logic               dirh_load,
    output logic               dirh_inc,
    output logic               a_load,
    output logic               x_load,
    output logic               y_load,
    output logic               read_write,
    output logic [2:0]         address_select,
    output logic [1:0]         store_select,
    output logic [1:0]         alu_select,
    output logic [1:0]         alu_opcode,
    output logic               illegal,
    output logic [STATE_W-1:0] fsm
);

    state_t     state;
    logic [7:0] opcode_q;
    dec_t       bus_dec;
    dec_t       q_dec;
    logic       rdy;
    logic       go;
    logic       indexed;
    logic       take_fix;
    logic       last_cyc;
    logic [1:0] adr1_op;
    logic       unused_dec;

    opcode_decoder u_bus_dec (.opcode(opcode),   .dec(bus_dec));
    opcode_decoder u_q_dec   (.opcode(opcode_q), .dec(q_dec));

    assign rdy      = (RDY_EN != 0) ? ready : 1'b1;
    assign go       = rdy & ~rst;
    assign indexed  = ((q_dec.mode == M_ABS) && (q_dec.index_reg != R_Z)) || (q_dec.mode == M_INDY);
    // Stores always take the fix cycle so the write never lands on an unfixed address.
    assign take_fix = (PAGE_PENALTY != 0) && indexed && (page_cross || q_dec.is_store);
    assign adr1_op  = (PAGE_PENALTY != 0) ? AOP_LD : AOP_ADR1;
    assign fsm      = STATE_W'(state);
    assign unused_dec = ^{q_dec.legal, bus_dec.op_class, bus_dec.index_reg,
                          bus_dec.target, bus_dec.is_store};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            opcode_q <= 8'hEA;
        end else if (rdy) begin
            case (state)
                S_FETCH: begin
                    opcode_q <= opcode;
                    if (bus_dec.legal) begin
                        case (bus_dec.mode)
                            M_IMM:   state <= S_IM0;
                            M_ZP:    state <= S_ZP0;
                            M_ABS:   state <= S_ABS0;
                            default: state <= S_IND_ZP0;
                        endcase
                    end
                end
                S_ZP0:     state <= S_ZP1;
                S_ABS0:    state <= S_ABS1;
                S_ABS1:    state <= take_fix ? S_ABSFIX : S_ABS2;
                S_ABSFIX:  state <= S_ABS2;
                S_IND_ZP0: state <= S_IND_ZP1;
                S_IND_ZP1: state <= S_IND_ZP2;
                S_IND_ZP2: state <= take_fix ? S_INDFIX : S_IND_ZP3;
                S_INDFIX:  state <= S_IND_ZP3;
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        instruction_load = 1'b0;
        increment_pc     = 1'b0;
        indirl_load      = 1'b0;
        dirl_load        = 1'b0;
        dirh_load        = 1'b0;
        dirh_inc         = 1'b0;
        a_load           = 1'b0;
        x_load           = 1'b0;
        y_load           = 1'b0;
        read_write       = 1'b0;
        illegal          = 1'b0;
        address_select   = AS_PC;
        store_select     = 2'd0;
        alu_select       = reg_sel(R_Z);
        alu_opcode       = AOP_LD;
        last_cyc         = 1'b0;
        case (state)
            S_FETCH: begin
                instruction_load = 1'b1;
                increment_pc     = 1'b1;
                illegal          = ~bus_dec.legal;
            end
            S_IM0: begin
                increment_pc = 1'b1;
                last_cyc     = 1'b1;
            end
            S_ZP0, S_ABS0: begin
                increment_pc = 1'b1;
                dirl_load    = 1'b1;
                alu_opcode   = AOP_ADR0;
                alu_select   = reg_sel(q_dec.index_reg);
            end
            S_ZP1: begin
                address_select = AS_ZERO;
                last_cyc       = 1'b1;
            end
            S_ABS1, S_IND_ZP2: begin
                increment_pc   = (state == S_ABS1);
                dirh_load      = 1'b1;
                alu_opcode     = adr1_op;
                address_select = (state == S_ABS1) ? AS_PC : AS_IND1;
            end
            S_ABSFIX, S_INDFIX: begin
                address_select = AS_ABS;
                dirh_inc       = page_cross;
            end
            S_ABS2, S_IND_ZP3: begin
                address_select = AS_ABS;
                last_cyc       = 1'b1;
            end
            S_IND_ZP0: begin
                increment_pc = 1'b1;
                indirl_load  = 1'b1;
                alu_opcode   = AOP_ADR0;
                alu_select   = (q_dec.mode == M_INDX) ? reg_sel(R_X) : reg_sel(R_Z);
            end
            S_IND_ZP1: begin
                address_select = AS_IND0;
                dirl_load      = 1'b1;
                alu_opcode     = AOP_ADR0;
                alu_select     = (q_dec.mode == M_INDY) ? reg_sel(R_Y) : reg_sel(R_Z);
            end
            default: ;
        endcase
        if (last_cyc) begin
            case (q_dec.op_class)
                C_LD: begin
                    a_load = (q_dec.target == R_A);
                    x_load = (q_dec.target == R_X);
                    y_load = (q_dec.target == R_Y);
                end
                C_ADC: begin
                    alu_opcode = AOP_ADC;
                    alu_select = reg_sel(R_A);
                    a_load     = 1'b1;
                end
                C_ST: begin
                    read_write   = 1'b1;
                    store_select = reg_sel(q_dec.target);
                end
                default: ;
            endcase
        end
        if (!go) begin
            instruction_load = 1'b0;
            increment_pc     = 1'b0;
            indirl_load      = 1'b0;
            dirl_load        = 1'b0;
            dirh_load        = 1'b0;
            dirh_inc         = 1'b0;
            a_load           = 1'b0;
            x_load           = 1'b0;
            y_load           = 1'b0;
            illegal          = 1'b0;
        end
        if (rst) begin
            read_write     = 1'b0;
            address_select = AS_PC;
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: instruction-level cycle model, per-cycle compare and literal pulse counts.
module tb_ctrl_sequencer;

    typedef struct packed {
        logic [5:0] fsm;
        logic       il, inc, indirl, dirl, dirh, dhi, al, xl, yl, rw;
        logic [2:0] addr;
        logic [1:0] ssel, asel, aop;
        logic       ill;
    } obs_t;

    localparam int K_OBS = 0, K_LIT = 1, K_CLR = 2;
    localparam int C_CYC = 0, C_AL = 1, C_INC = 2, C_RW = 3, C_DHI = 4, C_DH = 5, C_ILL = 6, C_XL = 7;

    typedef struct {
        int   kind;
        obs_t e;
        bit   rst_cyc;
        bit   rdy;
        int   tid;
        int   id;
        int   lit;
    } chk_t;

    logic       clk;
    logic       rst;
    logic [7:0] opcode;
    logic       ready;
    logic       page_cross;
    bit         use_pp0;
    chk_t       chk_q[$];
    obs_t       mdl[$];
    int         n_checks;
    int         n_err;
    int         tid;
    int         cnt[8];
    string      cnt_name[8] = '{"cycles", "a_load", "increment_pc", "read_write",
                                "dirh_inc", "dirh_load", "illegal", "x_load"};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       il, inc, indirl, dirl, dirh, dhi, al, xl, yl, rw, ill;
        logic [2:0] addr;
        logic [1:0] ssel, asel, aop;
        logic [5:0] fsm;
        obs_t       obs;
        ctrl_sequencer #(.STATE_W(6), .PAGE_PENALTY(g), .RDY_EN(1)) dut (
            .clk(clk), .rst(rst), .opcode(opcode), .ready(ready), .page_cross(page_cross),
            .instruction_load(il), .increment_pc(inc), .indirl_load(indirl),
            .dirl_load(dirl), .dirh_load(dirh), .dirh_inc(dhi),
            .a_load(al), .x_load(xl), .y_load(yl), .read_write(rw),
            .address_select(addr), .store_select(ssel), .alu_select(asel),
            .alu_opcode(aop), .illegal(ill), .fsm(fsm)
        );
        assign obs = {fsm, il, inc, indirl, dirl, dirh, dhi, al, xl, yl, rw, addr, ssel, asel, aop, ill};
    end

    // Single compare process: drains everything queued for this cycle in order.
    always @(negedge clk) begin : cmp
        chk_t c;
        obs_t a;
        obs_t m;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            a = use_pp0 ? g_dut[0].obs : g_dut[1].obs;
            if (c.kind == K_CLR) begin
                for (int k = 0; k < 8; k++) cnt[k] = 0;
            end else if (c.kind == K_LIT) begin
                n_checks++;
                if (cnt[c.id] != c.lit) begin
                    n_err++;
                    $display("FAIL test %0d count %s: got %0d expected %0d", c.tid, cnt_name[c.id], cnt[c.id], c.lit);
                end
            end else begin
                m = '1;
                if (c.rst_cyc) begin
                    m.fsm = '0; m.ssel = '0; m.asel = '0; m.aop = '0;
                end
                n_checks++;
                if ((a & m) !== (c.e & m)) begin
                    n_err++;
                    $display("FAIL test %0d cycle outputs at %0t: got %h expected %h", c.tid, $time, a & m, c.e & m);
                end
                if (!c.rst_cyc && c.rdy) cnt[C_CYC]++;
                cnt[C_AL]  += int'(a.al);
                cnt[C_INC] += int'(a.inc);
                cnt[C_RW]  += int'(a.rw);
                cnt[C_DHI] += int'(a.dhi);
                cnt[C_DH]  += int'(a.dirh);
                cnt[C_ILL] += int'(a.ill);
                cnt[C_XL]  += int'(a.xl);
            end
        end
    end

    function automatic obs_t blank(input int st);
        obs_t e;
        e = '0;
        e.fsm  = 6'(st);
        e.asel = 2'd3;
        e.aop  = 2'd3;
        return e;
    endfunction

    // Execute-cycle effects by operation kind: 0 load, 1 adc, 2 store, 3 read-only ALU op.
    function automatic obs_t fin(input obs_t ein, input int kd, input int tg);
        obs_t e;
        e = ein;
        if (kd == 0) begin
            e.al = (tg == 0); e.xl = (tg == 1); e.yl = (tg == 2);
        end else if (kd == 1) begin
            e.aop = 2'd2; e.asel = 2'd0; e.al = 1'b1;
        end else if (kd == 2) begin
            e.rw = 1'b1; e.ssel = 2'(tg);
        end
        return e;
    endfunction

    // Instruction-level model: expected output vector for every cycle of one instruction.
    task automatic build(input logic [7:0] op, input bit pcr, input bit pp);
        int md, ix, tg, kd;
        int mode_tab[8] = '{3, 1, 0, 2, 4, 1, 2, 2};
        int idx_tab[8]  = '{1, 3, 3, 3, 2, 1, 2, 1};
        logic [2:0] aaa, bbb;
        bit ok, fix;
        obs_t e;
        ok = 1; md = 0; ix = 3; tg = 0; kd = 3;
        aaa = op[7:5];
        bbb = op[4:2];
        if (op[1:0] == 2'b01) begin
            md = mode_tab[bbb];
            ix = idx_tab[bbb];
            kd = (aaa == 3'd5) ? 0 : (aaa == 3'd3) ? 1 : (aaa == 3'd4) ? 2 : 3;
            ok = (op != 8'h89);
        end else begin
            case (op)
                8'hA0: begin md = 0; tg = 2; kd = 0; end
                8'hA2: begin md = 0; tg = 1; kd = 0; end
                8'hA4: begin md = 1; tg = 2; kd = 0; end
                8'hA6: begin md = 1; tg = 1; kd = 0; end
                8'h84: begin md = 1; tg = 2; kd = 2; end
                8'h86: begin md = 1; tg = 1; kd = 2; end
                8'hAC: begin md = 2; tg = 2; kd = 0; end
                8'hAE: begin md = 2; tg = 1; kd = 0; end
                8'h8C: begin md = 2; tg = 2; kd = 2; end
                8'h8E: begin md = 2; tg = 1; kd = 2; end
                default: ok = 0;
            endcase
        end
        mdl.delete();
        e = blank(0); e.il = 1; e.inc = 1; e.ill = !ok;
        mdl.push_back(e);
        if (!ok) return;
        fix = pp && (pcr || kd == 2) && ((md == 2 && ix != 3) || md == 4);
        if (md == 0) begin
            e = blank(1); e.inc = 1; mdl.push_back(fin(e, kd, tg));
        end else if (md == 1 || md == 2) begin
            e = blank(md == 1 ? 2 : 4); e.inc = 1; e.dirl = 1; e.aop = 2'd0; e.asel = 2'(ix);
            mdl.push_back(e);
            if (md == 1) begin
                e = blank(3); e.addr = 3'd1; mdl.push_back(fin(e, kd, tg));
            end else begin
                e = blank(5); e.inc = 1; e.dirh = 1; e.aop = pp ? 2'd3 : 2'd1; mdl.push_back(e);
                if (fix) begin e = blank(6); e.addr = 3'd2; e.dhi = pcr; mdl.push_back(e); end
                e = blank(7); e.addr = 3'd2; mdl.push_back(fin(e, kd, tg));
            end
        end else begin
            e = blank(8); e.inc = 1; e.indirl = 1; e.aop = 2'd0; e.asel = (md == 3) ? 2'd1 : 2'd3;
            mdl.push_back(e);
            e = blank(9); e.addr = 3'd3; e.dirl = 1; e.aop = 2'd0; e.asel = (md == 4) ? 2'd2 : 2'd3;
            mdl.push_back(e);
            e = blank(10); e.addr = 3'd4; e.dirh = 1; e.aop = pp ? 2'd3 : 2'd1; mdl.push_back(e);
            if (fix) begin e = blank(11); e.addr = 3'd2; e.dhi = pcr; mdl.push_back(e); end
            e = blank(12); e.addr = 3'd2; mdl.push_back(fin(e, kd, tg));
        end
    endtask

    task automatic push(input int kind, input obs_t e, input bit rc, input bit rd, input int id, input int lit);
        chk_t c;
        c.kind = kind; c.e = e; c.rst_cyc = rc; c.rdy = rd; c.tid = tid; c.id = id; c.lit = lit;
        chk_q.push_back(c);
    endtask

    task automatic cycle(input bit r, input bit rd, input logic [7:0] op, input bit pcr, input obs_t e);
        @(posedge clk);
        #1;
        rst = r; ready = rd; opcode = op; page_cross = pcr;
        push(K_OBS, e, r, rd, 0, 0);
    endtask

    task automatic lit(input int id, input int v);
        push(K_LIT, '0, 1'b0, 1'b1, id, v);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 8'h02, 1'b0, '0);
    endtask

    task automatic run_instr(input logic [7:0] op, input bit pcr, input int stall_at,
                             input int stall_len, input int rst_at);
        obs_t s;
        tid++;
        build(op, pcr, !use_pp0);
        push(K_CLR, '0, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < mdl.size(); i++) begin
            if (i == stall_at) begin
                s = mdl[i];
                s.il = 0; s.inc = 0; s.indirl = 0; s.dirl = 0; s.dirh = 0; s.dhi = 0;
                s.al = 0; s.xl = 0; s.yl = 0; s.ill = 0;
                for (int k = 0; k < stall_len; k++) cycle(1'b0, 1'b0, (i == 0) ? op : 8'h02, pcr, s);
            end
            if (i == rst_at) begin
                cycle(1'b1, 1'b1, 8'h02, pcr, '0);
                return;
            end
            cycle(1'b0, 1'b1, (i == 0) ? op : 8'h02, pcr, mdl[i]);
        end
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; opcode = 8'hEA; page_cross = 1'b0;
        use_pp0 = 1'b0; n_checks = 0; n_err = 0; tid = 0;
        do_reset(2);

        run_instr(8'hA9, 0, -1, 0, -1); lit(C_CYC, 2); lit(C_AL, 1); lit(C_INC, 2);
        run_instr(8'h8D, 0, -1, 0, -1); lit(C_CYC, 4); lit(C_RW, 1); lit(C_AL, 0);
        run_instr(8'hBD, 1, -1, 0, -1); lit(C_CYC, 5); lit(C_DHI, 1); lit(C_AL, 1);
        run_instr(8'hBD, 0, -1, 0, -1); lit(C_CYC, 4); lit(C_DHI, 0);
        run_instr(8'hBD, 1, 2, 3, -1);  lit(C_CYC, 5); lit(C_INC, 3); lit(C_DH, 1);
        run_instr(8'h02, 0, -1, 0, -1); lit(C_ILL, 1); lit(C_CYC, 1);
        run_instr(8'h99, 0, -1, 0, -1); lit(C_CYC, 5); lit(C_DHI, 0); lit(C_RW, 1);
        run_instr(8'h91, 1, -1, 0, -1); lit(C_CYC, 6); lit(C_DHI, 1); lit(C_RW, 1);
        run_instr(8'h86, 0, -1, 0, -1); lit(C_CYC, 3); lit(C_RW, 1);
        run_instr(8'hAE, 0, -1, 0, -1); lit(C_CYC, 4); lit(C_XL, 1);
        run_instr(8'hA0, 0, -1, 0, -1); lit(C_CYC, 2);
        run_instr(8'h01, 1, -1, 0, -1); lit(C_CYC, 5); lit(C_AL, 0); lit(C_DHI, 0);
        run_instr(8'h55, 0, -1, 0, -1); lit(C_CYC, 3);
        run_instr(8'h89, 0, -1, 0, -1); lit(C_ILL, 1);
        run_instr(8'h71, 1, -1, 0, 2);  lit(C_RW, 0); lit(C_INC, 2);
        run_instr(8'hFD, 0, -1, 0, -1); lit(C_CYC, 4); lit(C_AL, 0);

        use_pp0 = 1'b1;
        do_reset(2);
        run_instr(8'h71, 1, -1, 0, -1); lit(C_CYC, 5); lit(C_AL, 1);
        run_instr(8'hBD, 1, -1, 0, -1); lit(C_CYC, 4); lit(C_DHI, 0);
        run_instr(8'h99, 1, -1, 0, -1); lit(C_CYC, 4); lit(C_RW, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
